// File: rtl/tdm_demux8.sv
// tdm_demux8: 1-to-8 time-division demultiplexer.
// Serial bits arrive one per enabled cycle. Slot k of a frame is routed to
// channel k. Each completed frame is published on ch_out with a one-cycle
// word_valid pulse. A frame strobe that arrives mid-frame restarts assembly
// and raises a one-cycle sync_err pulse.
module tdm_demux8 #(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             frame,
    input  logic             din,
    output logic [N_CH-1:0]  ch_out,
    output logic             word_valid,
    output logic [N_CH-1:0]  route,
    output logic [SEL_W-1:0] slot,
    output logic             sync_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_CH - 1);
    localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] slot_reg, slot_next;
    logic [N_CH-1:0]  shadow_reg, shadow_next;
    logic [N_CH-1:0]  ch_out_reg, ch_out_next;
    logic             word_valid_reg, word_valid_next;
    logic             sync_err_reg, sync_err_next;
    logic             route_active;

    // State and datapath registers; a reset at any point discards the partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            slot_reg       <= '0;
            shadow_reg     <= '0;
            ch_out_reg     <= '0;
            word_valid_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            slot_reg       <= slot_next;
            shadow_reg     <= shadow_next;
            ch_out_reg     <= ch_out_next;
            word_valid_reg <= word_valid_next;
            sync_err_reg   <= sync_err_next;
        end
    end

    // Next-state and datapath update; frame beats completion when both apply.
    always_comb begin
        state_next      = state_reg;
        slot_next       = slot_reg;
        shadow_next     = shadow_reg;
        ch_out_next     = ch_out_reg;
        word_valid_next = 1'b0;
        sync_err_next   = 1'b0;
        if (en) begin
            case (state_reg)
                IDLE: begin
                    if (frame) begin
                        shadow_next[0] = din;
                        slot_next      = SLOT_ONE;
                        state_next     = RUN;
                    end
                end
                RUN: begin
                    if (frame) begin
                        // Resync: restart assembly with this bit as slot 0.
                        sync_err_next  = 1'b1;
                        shadow_next    = '0;
                        shadow_next[0] = din;
                        slot_next      = SLOT_ONE;
                    end else if (slot_reg == LAST_SLOT) begin
                        // Last bit goes straight to the output word, not via shadow.
                        ch_out_next     = {din, shadow_reg[N_CH-2:0]};
                        word_valid_next = 1'b1;
                        slot_next       = '0;
                        state_next      = IDLE;
                    end else begin
                        shadow_next[slot_reg] = din;
                        slot_next             = slot_reg + SLOT_ONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // The route decode is live while running, or on the slot-0 strobe cycle in IDLE.
    assign route_active = rst_n && ((state_reg == RUN) || (en && frame));

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_route
            assign route[gi] = route_active && (slot_reg == SEL_W'(gi));
        end
    endgenerate

    assign ch_out     = ch_out_reg;
    assign word_valid = word_valid_reg;
    assign slot       = slot_reg;
    assign sync_err   = sync_err_reg;

endmodule

// File: tb/tb_tdm_demux8.sv
// Testbench for tdm_demux8: directed scenarios plus randomized traffic, all
// compared against a frame-level reference model (list of collected bits).
module tb_tdm_demux8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       frame;
    logic       din;
    logic [7:0] ch_out;
    logic       word_valid;
    logic [7:0] route;
    logic [2:0] slot;
    logic       sync_err;

    tdm_demux8 #(.N_CH(8), .SEL_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .frame      (frame),
        .din        (din),
        .ch_out     (ch_out),
        .word_valid (word_valid),
        .route      (route),
        .slot       (slot),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // Reference model: a frame is a list of bits collected since the strobe.
    bit         m_active;
    int         m_cnt;
    bit [7:0]   m_bits;
    logic [7:0] m_ch;
    logic       m_wv;
    logic       m_se;
    logic [7:0] exp_route;
    logic [7:0] obs_route;

    task automatic model_reset();
        m_active = 0;
        m_cnt    = 0;
        m_bits   = '0;
        m_ch     = '0;
        m_wv     = 0;
        m_se     = 0;
    endtask

    // One clock cycle: drive at negedge, sample route before the edge,
    // advance the model, and leave time at posedge+1 for output checks.
    task automatic step(input logic e, input logic f, input logic d);
        @(negedge clk);
        en = e; frame = f; din = d;
        #1;
        obs_route = route;
        exp_route = m_active ? (8'h01 << m_cnt) : ((e && f) ? 8'h01 : 8'h00);
        @(posedge clk);
        #1;
        cyc++;
        m_wv = 0;
        m_se = 0;
        if (e) begin
            if (f) begin
                if (m_active) m_se = 1;
                m_bits    = '0;
                m_bits[0] = d;
                m_cnt     = 1;
                m_active  = 1;
            end else if (m_active) begin
                m_bits[m_cnt] = d;
                m_cnt++;
                if (m_cnt == 8) begin
                    m_ch     = m_bits;
                    m_wv     = 1;
                    m_active = 0;
                    m_cnt    = 0;
                    $display("[%0t] frame complete: ch_out expected 0x%02h", $time, m_bits);
                end
            end
        end
    endtask

    // Send one full frame of value v (slot k carries v[k]), checking every cycle.
    task automatic send_frame(input logic [7:0] v, output int wv_cyc);
        logic [7:0] vv;
        vv = v;
        wv_cyc = -1;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, (k == 0), vv[k]);
            checks++;
            if ({ch_out, word_valid, sync_err, slot, obs_route} !== {m_ch, m_wv, m_se, 3'(m_cnt), exp_route})
                $display("FAIL frame_step k=%0d got ch=%02h wv=%b se=%b slot=%0d route=%02h want ch=%02h wv=%b se=%b slot=%0d route=%02h",
                         k, ch_out, word_valid, sync_err, slot, obs_route, m_ch, m_wv, m_se, m_cnt, exp_route);
            else passes++;
            if (word_valid === 1'b1) wv_cyc = cyc;
        end
    endtask

    task automatic test_reset();
        en = 1'b1; frame = 1'b0; din = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({ch_out, word_valid, sync_err, slot, route} !== 22'd0)
            $display("FAIL reset_initial got ch=%02h wv=%b se=%b slot=%0d route=%02h want all 0",
                     ch_out, word_valid, sync_err, slot, route);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (slot !== 3'd3) $display("FAIL reset_prestream slot got %0d want 3", slot);
        else passes++;
        // Assert reset between edges, mid-stream, and look without any clock edge.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ch_out, word_valid, sync_err, slot, route} !== 22'd0)
            $display("FAIL reset_async_midstream got ch=%02h wv=%b se=%b slot=%0d route=%02h want all 0",
                     ch_out, word_valid, sync_err, slot, route);
        else passes++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0; frame = 1'b0;
    endtask

    task automatic test_normal_frame();
        int start;
        int wv_cyc;
        logic [7:0] prev_route;
        start = cyc;
        // Bits 1,0,1,1,0,0,1,0 on slots 0..7 give 0x4D.
        send_frame(8'h4D, wv_cyc);
        checks++;
        if (ch_out !== 8'h4D) $display("FAIL normal_ch_out got %02h want 4d", ch_out);
        else passes++;
        checks++;
        if (wv_cyc - start !== 8) $display("FAIL normal_latency got %0d want 8", wv_cyc - start);
        else passes++;
        // Route for the last slot must have been 0x80 (sampled before the last edge).
        prev_route = obs_route;
        checks++;
        if (prev_route !== 8'h80) $display("FAIL normal_route_last got %02h want 80", prev_route);
        else passes++;
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b0 || ch_out !== 8'h4D)
            $display("FAIL normal_wv_pulse got wv=%b ch=%02h want wv=0 ch=4d", word_valid, ch_out);
        else passes++;
    endtask

    task automatic test_enable_gaps();
        logic [7:0] v;
        int start;
        int wv_cyc;
        v = 8'h4D;
        start = cyc;
        wv_cyc = -1;
        for (int k = 0; k < 4; k++) step(1'b1, (k == 0), v[k]);
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b0, g[0]);
            checks++;
            if (slot !== 3'd4 || word_valid !== 1'b0)
                $display("FAIL gap_hold g=%0d got slot=%0d wv=%b want slot=4 wv=0", g, slot, word_valid);
            else passes++;
        end
        for (int k = 4; k < 8; k++) begin
            step(1'b1, 1'b0, v[k]);
            if (word_valid === 1'b1) wv_cyc = cyc;
        end
        checks++;
        if (ch_out !== 8'h4D) $display("FAIL gap_ch_out got %02h want 4d", ch_out);
        else passes++;
        checks++;
        if (wv_cyc - start !== 11) $display("FAIL gap_latency got %0d want 11", wv_cyc - start);
        else passes++;
    endtask

    task automatic test_resync();
        int start;
        int wv_cyc;
        for (int k = 0; k < 5; k++) step(1'b1, (k == 0), 1'($urandom_range(0, 1)));
        checks++;
        if (slot !== 3'd5) $display("FAIL resync_pre slot got %0d want 5", slot);
        else passes++;
        start = cyc;
        wv_cyc = -1;
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if ({sync_err, slot, ch_out, word_valid} !== {1'b1, 3'd1, 8'h4D, 1'b0})
            $display("FAIL resync_pulse got se=%b slot=%0d ch=%02h wv=%b want se=1 slot=1 ch=4d wv=0",
                     sync_err, slot, ch_out, word_valid);
        else passes++;
        for (int k = 1; k < 8; k++) begin
            step(1'b1, 1'b0, 1'b1);
            if (k == 1) begin
                checks++;
                if (sync_err !== 1'b0) $display("FAIL resync_pulse_width got se=%b want 0", sync_err);
                else passes++;
            end
            if (word_valid === 1'b1) wv_cyc = cyc;
        end
        checks++;
        if (ch_out !== 8'hFF || wv_cyc - start !== 8)
            $display("FAIL resync_complete got ch=%02h lat=%0d want ch=ff lat=8", ch_out, wv_cyc - start);
        else passes++;
    endtask

    task automatic test_frame_last_slot();
        for (int k = 0; k < 7; k++) step(1'b1, (k == 0), 1'b0);
        checks++;
        if (slot !== 3'd7) $display("FAIL last_pre slot got %0d want 7", slot);
        else passes++;
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if ({sync_err, word_valid, ch_out, slot} !== {1'b1, 1'b0, 8'hFF, 3'd1})
            $display("FAIL last_slot_frame got se=%b wv=%b ch=%02h slot=%0d want se=1 wv=0 ch=ff slot=1",
                     sync_err, word_valid, ch_out, slot);
        else passes++;
        for (int k = 1; k < 8; k++) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (ch_out !== 8'h00 || m_ch !== 8'h00)
            $display("FAIL last_slot_refill got ch=%02h want 00", ch_out);
        else passes++;
    endtask

    task automatic test_async_reset();
        int wv1;
        int wv2;
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b1, (k == 0), 1'b1);
        for (int k = 0; k < 1; k++) step(1'b1, 1'b0, 1'b1);
        // Complete this all-ones frame so ch_out is nonzero before the reset.
        for (int k = 0; k < 4; k++) step(1'b1, (k == 0), 1'b1);
        checks++;
        if (slot !== 3'd4 || ch_out !== 8'hFF)
            $display("FAIL areset_pre got slot=%0d ch=%02h want slot=4 ch=ff", slot, ch_out);
        else passes++;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ch_out, word_valid, sync_err, slot, route} !== 22'd0)
            $display("FAIL areset_clear got ch=%02h wv=%b se=%b slot=%0d route=%02h want all 0",
                     ch_out, word_valid, sync_err, slot, route);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'hA5, wv1);
        checks++;
        if (ch_out !== 8'hA5) $display("FAIL areset_frame_a5 got %02h want a5", ch_out);
        else passes++;
        send_frame(8'h3C, wv2);
        checks++;
        if (ch_out !== 8'h3C || wv2 - wv1 !== 8)
            $display("FAIL back_to_back got ch=%02h spacing=%0d want ch=3c spacing=8", ch_out, wv2 - wv1);
        else passes++;
    endtask

    task automatic test_random();
        logic e, f, d;
        int errs;
        errs = 0;
        for (int i = 0; i < 600; i++) begin
            e = ($urandom_range(0, 9) < 8);
            f = ($urandom_range(0, 11) == 0);
            d = 1'($urandom_range(0, 1));
            step(e, f, d);
            checks++;
            if ({ch_out, word_valid, sync_err, slot, obs_route} !== {m_ch, m_wv, m_se, 3'(m_cnt), exp_route}) begin
                errs++;
                if (errs < 10)
                    $display("FAIL random_cycle i=%0d got ch=%02h wv=%b se=%b slot=%0d route=%02h want ch=%02h wv=%b se=%b slot=%0d route=%02h",
                             i, ch_out, word_valid, sync_err, slot, obs_route, m_ch, m_wv, m_se, m_cnt, exp_route);
            end else passes++;
        end
    endtask

    initial begin
        en = 1'b0; frame = 1'b0; din = 1'b0; rst_n = 1'b0;
        test_reset();
        test_normal_frame();
        test_enable_gaps();
        test_resync();
        test_frame_last_slot();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Sequential 1-to-8 time-division demultiplexer. It is the receive-side counterpart of the team's 8:1 select mux.
- A serial bit stream arrives one bit per enabled cycle. Bit k of a frame is routed to channel k, using the same slot numbering as the mux select {p,q,r}=k → a_k.
- The eight channel bits are assembled in a shadow register and published as a parallel word with a one-cycle valid pulse.
- Frame alignment comes from a frame strobe; misalignment is flagged.

Parameters:
- N_CH, 8, number of output channels; must equal 2**SEL_W.
- SEL_W, 3, width of the slot counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  sample enable; when low, all state holds.
- frame  input  1  marks din as the slot-0 bit of a new frame; qualified by en.
- din  input  1  serial data bit.
- ch_out  output  N_CH  last completed frame; bit k = slot k.
- word_valid  output  1  one-cycle pulse: ch_out just updated.
- route  output  N_CH  one-hot decode of the slot being written this cycle; 0 in IDLE.
- slot  output  SEL_W  current slot counter.
- sync_err  output  1  one-cycle pulse: frame seen mid-frame.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-frame):
  - Registers: state=IDLE, slot=0, shadow=0, ch_out=0, word_valid=0, sync_err=0; route=0.
  - A partially assembled frame is discarded.
- State IDLE:
  - en=1, frame=1: shadow[0]<=din, slot<=1, state<=RUN.
  - en=1, frame=0: din dropped, no state change.
  - en=0: hold.
- State RUN, en=1, frame=0, slot<N_CH-1: shadow[slot]<=din, slot<=slot+1.
- State RUN, en=1, frame=0, slot==N_CH-1:
  - Same edge: ch_out<={din, shadow[N_CH-2:0]}, word_valid<=1, slot<=0, state<=IDLE.
- State RUN, en=1, frame=1 (any slot, including N_CH-1):
  - Resync: sync_err<=1, shadow<=0 with shadow[0]<=din, slot<=1, stay RUN.
  - ch_out is unchanged and word_valid is not asserted; frame has priority over completion.
- en=0 in RUN: slot, shadow and state hold, so gaps are allowed anywhere within a frame.
- word_valid and sync_err:
  - Registered, high for exactly one cycle after the causing edge, deasserted on the next edge regardless of en.
- route:
  - Combinational one-hot of slot when state=RUN, or when state=IDLE and en&frame (slot 0). Otherwise 0.
  - Formula: route[k] = (k==slot) & (RUN | (en&frame)).
- Latency:
  - The last bit is sampled at edge E; ch_out and word_valid are visible after E.
  - Minimum frame period is N_CH enabled cycles.
  - Back-to-back frames (frame on the cycle after slot N_CH-1) lose no cycles.
- ch_out holds its value until the next completed frame. sync_err never clears ch_out.
- slot wraps only through completion (N_CH-1→0) or resync (→1). It never counts past N_CH-1.

Test Plan:
- Reset: hold rst_n=0 mid-stream → ch_out=0, word_valid=0, sync_err=0, slot=0, route=0 without waiting for a clk edge.
- Normal frame: en=1; frame=1 on cycle 0; din=1,0,1,1,0,0,1,0 for slots 0..7 →
  - route steps 0x01,0x02,…,0x80.
  - After the 8th edge: ch_out=0x4D, word_valid high exactly one cycle.
- Enable gaps: same frame with en=0 for 3 cycles after slot 3 → slot holds at 4, final ch_out=0x4D, word_valid 3 cycles later than the no-gap case.
- Resync: after a frame with ch_out=0x4D, assert frame again at slot 5 →
  - sync_err one-cycle pulse, slot=1, ch_out stays 0x4D.
  - The restarted frame of all-ones completes 8 cycles after its start with ch_out=0xFF.
- Frame on last slot: frame=1 at slot 7 → sync_err=1, no word_valid, ch_out unchanged.
- Async reset mid-frame at slot 4 → outputs clear immediately; after release, a full frame 0xA5 yields ch_out=0xA5. Then a back-to-back frame 0x3C yields a second word_valid exactly 8 cycles after the first.
